// File: rtl/accel_log_pkg.sv
// Shared types and word layout for the accelerometer sample logger.
// Each sample becomes two 32-bit words: {Y, X} then {SEQ, Z}.
package accel_log_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_e;

    localparam int          OFS_W       = 16;
    localparam int          W_HI_LSB    = 16;
    localparam int          W_LO_MSB    = 15;
    localparam logic [3:0]  BYTE_EN_ALL = 4'hF;
    localparam logic [15:0] DROP_MAX    = 16'hFFFF;

    function automatic logic [31:0] pack_word(
        input logic [15:0] hi,
        input logic [15:0] lo
    );
        logic [31:0] w;
        w[31:W_HI_LSB] = hi;
        w[W_LO_MSB:0]  = lo;
        return w;
    endfunction

endpackage

// File: rtl/accel_log_addr_gen.sv
// Circular word-offset generator for the sample log.
// Advances by one sample (two words) per commit and flags half/wrap events.
module accel_log_addr_gen
    import accel_log_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance,
    input  logic             clear,
    output logic [OFS_W-1:0] wr_ofs,
    output logic             wrapped,
    output logic             half_pulse,
    output logic             wrap_pulse
);

    localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(DEPTH_WORDS - 2);
    localparam logic [OFS_W-1:0] HALF_OFS = OFS_W'(DEPTH_WORDS / 2);

    logic [OFS_W-1:0] ofs_q, ofs_d, ofs_nxt;
    logic             wrapped_q, wrapped_d;
    logic             half_q, half_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        ofs_d     = ofs_q;
        wrapped_d = wrapped_q;
        half_d    = 1'b0;
        wrap_d    = 1'b0;
        ofs_nxt   = (ofs_q == LAST_OFS) ? '0 : ofs_q + OFS_W'(2);
        if (clear) begin
            ofs_d     = '0;
            wrapped_d = 1'b0;
        end else if (advance) begin
            ofs_d = ofs_nxt;
            if (ofs_nxt == '0) begin
                wrapped_d = 1'b1;
                wrap_d    = 1'b1;
            end
            if (ofs_nxt == HALF_OFS) begin
                half_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ofs_q     <= '0;
            wrapped_q <= 1'b0;
            half_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            ofs_q     <= ofs_d;
            wrapped_q <= wrapped_d;
            half_q    <= half_d;
            wrap_q    <= wrap_d;
        end
    end

    assign wr_ofs     = ofs_q;
    assign wrapped    = wrapped_q;
    assign half_pulse = half_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/accel_sample_logger.sv
// Packs X/Y/Z accelerometer samples into two words and writes them
// into a circular RAM log over an Avalon-MM master without waitrequest.
module accel_sample_logger
    import accel_log_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h8000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [15:0] in_z,
    input  logic        mem_reset_req,
    output logic [15:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [15:0] wr_ofs,
    output logic        wrapped,
    output logic        half_pulse,
    output logic        wrap_pulse,
    output logic [15:0] drop_count
);

    state_e      state_q, state_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] z_q, z_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        write_q, write_d;
    logic        advance;

    assign advance = (state_q == WR1) && !mem_reset_req && !clear;

    accel_log_addr_gen #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (advance),
        .clear      (clear),
        .wr_ofs     (wr_ofs),
        .wrapped    (wrapped),
        .half_pulse (half_pulse),
        .wrap_pulse (wrap_pulse)
    );

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        z_d     = z_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        if (clear) begin
            state_d = IDLE;
            seq_d   = '0;
            write_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && enable) begin
                        z_d     = in_z;
                        addr_d  = BASE_ADDR + wr_ofs;
                        data_d  = pack_word(in_y, in_x);
                        write_d = 1'b1;
                        state_d = WR0;
                    end else if (in_valid && drop_q != DROP_MAX) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
                // A held mem_reset_req keeps the same word on the bus until it lands.
                WR0: begin
                    if (!mem_reset_req) begin
                        addr_d  = BASE_ADDR + wr_ofs + 16'd1;
                        data_d  = pack_word(seq_q, z_q);
                        state_d = WR1;
                    end
                end
                WR1: begin
                    if (!mem_reset_req) begin
                        write_d = 1'b0;
                        seq_d   = seq_q + 16'd1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    write_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            seq_q   <= '0;
            z_q     <= '0;
            drop_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            z_q     <= z_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign avm_address    = addr_q;
    assign avm_byteenable = BYTE_EN_ALL;
    assign avm_chipselect = write_q;
    assign avm_write      = write_q;
    assign avm_writedata  = data_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_accel_sample_logger.sv
// Directed self-checking bench for accel_sample_logger.
// A negedge monitor records every committed RAM write for the scenario tasks.
module tb_accel_sample_logger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic [15:0] in_z = '0;
    logic        mem_reset_req = 1'b0;
    logic [15:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [15:0] wr_ofs;
    logic        wrapped;
    logic        half_pulse;
    logic        wrap_pulse;
    logic [15:0] drop_count;

    int vectors = 0;
    int miscompares = 0;

    logic [47:0] wq[$];

    accel_sample_logger dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_x           (in_x),
        .in_y           (in_y),
        .in_z           (in_z),
        .mem_reset_req  (mem_reset_req),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .wr_ofs         (wr_ofs),
        .wrapped        (wrapped),
        .half_pulse     (half_pulse),
        .wrap_pulse     (wrap_pulse),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && avm_write && avm_chipselect && !mem_reset_req)
            wq.push_back({avm_address, avm_writedata});
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
        in_x = x;
        in_y = y;
        in_z = z;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL rst_in_ready: got %b want 1", in_ready); miscompares++;
        end
        vectors++;
        if (avm_byteenable !== 4'hF) begin
            $display("FAIL rst_be: got %h want f", avm_byteenable); miscompares++;
        end
        vectors++;
        if ({avm_write, avm_chipselect, avm_address, avm_writedata} !== 50'd0) begin
            $display("FAIL rst_avm: got w%b cs%b a%h d%h want 0", avm_write,
                     avm_chipselect, avm_address, avm_writedata); miscompares++;
        end
        vectors++;
        if ({wr_ofs, wrapped, half_pulse, wrap_pulse, drop_count} !== 35'd0) begin
            $display("FAIL rst_status: got ofs%h wr%b h%b w%b dc%h want 0", wr_ofs,
                     wrapped, half_pulse, wrap_pulse, drop_count); miscompares++;
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [47:0] e;
        wq.delete();
        send(16'h0001, 16'h0002, 16'h0003);
        vectors++;
        if (avm_write !== 1'b1 || avm_address !== 16'h8000 || avm_writedata !== 32'h00020001) begin
            $display("FAIL single_w0: got w%b a%h d%h want w1 a8000 d00020001",
                     avm_write, avm_address, avm_writedata); miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL single_rdy_k0: got %b want 0", in_ready); miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (avm_write !== 1'b1 || avm_address !== 16'h8001 || avm_writedata !== 32'h00000003) begin
            $display("FAIL single_w1: got w%b a%h d%h want w1 a8001 d00000003",
                     avm_write, avm_address, avm_writedata); miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL single_rdy_k1: got %b want 0", in_ready); miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || avm_write !== 1'b0 || wr_ofs !== 16'd2) begin
            $display("FAIL single_done: got rdy%b w%b ofs%h want rdy1 w0 ofs0002",
                     in_ready, avm_write, wr_ofs); miscompares++;
        end
        e = (wq.size() == 2) ? wq[1] : 48'hx;
        vectors++;
        if (wq.size() != 2 || wq[0] !== 48'h8000_00020001 || e !== 48'h8001_00000003) begin
            $display("FAIL single_ram: got n=%0d want 2 writes", wq.size()); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int err = 0;
        int half_cnt = 0, half_at = 0, wrap_cnt = 0, wrap_at = 0;
        logic [15:0] x, y, z, a;
        logic [47:0] e0, e1;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        wq.delete();
        for (int i = 1; i <= 2049; i++) begin
            x = 16'(i);
            y = ~x;
            z = x ^ 16'h5A5A;
            a = 16'h8000 + 16'(2 * ((i - 1) % 2048));
            send(x, y, z);
            repeat (2) @(posedge clk);
            #1;
            if (half_pulse) begin half_cnt++; half_at = i; end
            if (wrap_pulse) begin wrap_cnt++; wrap_at = i; end
            if (wq.size() != 2) begin
                err++;
            end else begin
                e0 = wq.pop_front();
                e1 = wq.pop_front();
                if (e0 !== {a, y, x} || e1 !== {a + 16'd1, 16'(i - 1), z}) err++;
            end
            if (i == 2048) begin
                vectors++;
                if (wr_ofs !== 16'd0 || wrapped !== 1'b1) begin
                    $display("FAIL b2b_wrap_state: got ofs%h wr%b want 0000 1",
                             wr_ofs, wrapped); miscompares++;
                end
            end
            wq.delete();
        end
        vectors++;
        if (err != 0) begin
            $display("FAIL b2b_writes: got %0d bad samples want 0", err); miscompares++;
        end
        vectors++;
        if (half_cnt != 1 || half_at != 1024) begin
            $display("FAIL b2b_half: got cnt%0d at%0d want 1 at 1024", half_cnt, half_at);
            miscompares++;
        end
        vectors++;
        if (wrap_cnt != 1 || wrap_at != 2048) begin
            $display("FAIL b2b_wrap: got cnt%0d at%0d want 1 at 2048", wrap_cnt, wrap_at);
            miscompares++;
        end
        vectors++;
        if (wr_ofs !== 16'd2 || wrapped !== 1'b1) begin
            $display("FAIL b2b_2049: got ofs%h wr%b want 0002 1", wr_ofs, wrapped);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        logic [47:0] e;
        wq.delete();
        send(16'h1111, 16'h2222, 16'h3333);
        @(posedge clk); #1;
        mem_reset_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (avm_write !== 1'b1 || avm_address !== 16'h8003 ||
                avm_writedata !== 32'h0801_3333 || wr_ofs !== 16'd2) begin
                $display("FAIL stall_hold%0d: got w%b a%h d%h ofs%h want w1 a8003 d08013333 ofs0002",
                         c, avm_write, avm_address, avm_writedata, wr_ofs); miscompares++;
            end
        end
        mem_reset_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (wr_ofs !== 16'd4 || in_ready !== 1'b1) begin
            $display("FAIL stall_ofs: got ofs%h rdy%b want 0004 1", wr_ofs, in_ready);
            miscompares++;
        end
        e = (wq.size() == 2) ? wq[1] : 48'hx;
        vectors++;
        if (wq.size() != 2 || wq[0] !== 48'h8002_22221111 || e !== 48'h8003_08013333) begin
            $display("FAIL stall_ram: got n=%0d want 2 writes", wq.size()); miscompares++;
        end
    endtask

    task automatic test_drop();
        logic [47:0] e;
        wq.delete();
        enable = 1'b0;
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        vectors++;
        if (drop_count !== 16'd3 || wq.size() != 0) begin
            $display("FAIL drop_cnt: got dc%h n=%0d want 0003 0", drop_count, wq.size());
            miscompares++;
        end
        enable = 1'b1;
        send(16'hAAAA, 16'hBBBB, 16'hCCCC);
        repeat (2) @(posedge clk);
        #1;
        e = (wq.size() == 2) ? wq[1] : 48'hx;
        vectors++;
        if (wq.size() != 2 || wq[0] !== 48'h8004_BBBBAAAA || e !== 48'h8005_0802CCCC) begin
            $display("FAIL drop_resume: got n=%0d want 2 writes", wq.size()); miscompares++;
        end
    endtask

    task automatic test_clear();
        logic [47:0] e;
        wq.delete();
        send(16'h0101, 16'h0202, 16'h0303);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || avm_write !== 1'b0 || wr_ofs !== 16'd0 || wrapped !== 1'b0) begin
            $display("FAIL clear_state: got rdy%b w%b ofs%h wr%b want 1 0 0000 0",
                     in_ready, avm_write, wr_ofs, wrapped); miscompares++;
        end
        vectors++;
        if (drop_count !== 16'd3) begin
            $display("FAIL clear_drop: got %h want 0003", drop_count); miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wq.size() != 1 || wq[0] !== 48'h8006_02020101) begin
            $display("FAIL clear_partial: got n=%0d want 1 word0 only", wq.size());
            miscompares++;
        end
        wq.delete();
        send(16'h0F0F, 16'hF0F0, 16'h7777);
        repeat (2) @(posedge clk);
        #1;
        e = (wq.size() == 2) ? wq[1] : 48'hx;
        vectors++;
        if (wq.size() != 2 || wq[0] !== 48'h8000_F0F00F0F || e !== 48'h8001_00007777) begin
            $display("FAIL clear_next: got n=%0d want 2 writes at 8000", wq.size());
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        send(16'h1234, 16'h5678, 16'h9ABC);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || avm_write !== 1'b0 || avm_chipselect !== 1'b0 ||
            avm_address !== 16'd0 || avm_writedata !== 32'd0 || avm_byteenable !== 4'hF) begin
            $display("FAIL areset_avm: got rdy%b w%b a%h d%h be%h want 1 0 0000 0 f",
                     in_ready, avm_write, avm_address, avm_writedata, avm_byteenable);
            miscompares++;
        end
        vectors++;
        if (wr_ofs !== 16'd0 || drop_count !== 16'd0 || wrapped !== 1'b0) begin
            $display("FAIL areset_status: got ofs%h dc%h wr%b want 0", wr_ofs,
                     drop_count, wrapped); miscompares++;
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (wr_ofs !== 16'd0 || in_ready !== 1'b1 || avm_write !== 1'b0) begin
            $display("FAIL areset_release: got ofs%h rdy%b w%b want 0000 1 0",
                     wr_ofs, in_ready, avm_write); miscompares++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_drop();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
